// File: rtl/multiport_register_file.sv
// Parametrised multi-port register file with byte enables, write-to-read bypass,
// a pending-register scoreboard and a commit-trace queue feeding debug_wb_*.
module multiport_register_file #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int BYPASS      = 1,
  parameter int TRACE_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]    readAddress,
  output logic [READ_PORTS*DATA_WIDTH-1:0]    readOutput,
  output logic [READ_PORTS-1:0]               readBusy,
  input  logic [WRITE_PORTS-1:0]              writeEnable,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0]   writeAddress,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]   writeData,
  input  logic [WRITE_PORTS*DATA_WIDTH/8-1:0] writeByteEnable,
  input  logic [WRITE_PORTS*32-1:0]           writePC,
  input  logic                                reserveValid,
  input  logic [ADDR_WIDTH-1:0]               reserveAddress,
  output logic [31:0]                         debug_wb_pc,
  output logic [DATA_WIDTH/8-1:0]             debug_wb_rf_wen,
  output logic [ADDR_WIDTH-1:0]               debug_wb_rf_wnum,
  output logic [DATA_WIDTH-1:0]               debug_wb_rf_wdata,
  output logic                                traceOverflow
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] TRACE_CAP = CNT_W'(TRACE_DEPTH);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [BYTES-1:0]      be_t;

  typedef struct packed {
    logic [31:0] pc;
    addr_t       wnum;
    be_t         wen;
    word_t       wdata;
  } trace_t;

  function automatic word_t merge_bytes(word_t base, word_t data, be_t be);
    word_t v;
    v = base;
    for (int b = 0; b < BYTES; b++)
      if (be[b]) v[b*8 +: 8] = data[b*8 +: 8];
    return v;
  endfunction

  word_t            regs [DEPTH];
  logic [DEPTH-1:0] pending;
  trace_t           fifo [TRACE_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;

  addr_t             w_addr [WRITE_PORTS];
  word_t             w_data [WRITE_PORTS];
  be_t               w_be   [WRITE_PORTS];
  logic [31:0]       w_pc   [WRITE_PORTS];
  logic [WRITE_PORTS-1:0] w_eff;
  word_t             w_post [WRITE_PORTS];

  // w_post[k] is the register value after ports 0..k have been applied, which
  // is both what port k's trace entry shows and (for the last port) the final value.
  always_comb begin
    for (int k = 0; k < WRITE_PORTS; k++) begin
      w_addr[k] = writeAddress[k*ADDR_WIDTH +: ADDR_WIDTH];
      w_data[k] = writeData[k*DATA_WIDTH +: DATA_WIDTH];
      w_be[k]   = writeByteEnable[k*BYTES +: BYTES];
      w_pc[k]   = writePC[k*32 +: 32];
      w_eff[k]  = writeEnable[k] && (w_addr[k] != '0) && (w_be[k] != '0);
    end
    for (int k = 0; k < WRITE_PORTS; k++) begin
      w_post[k] = regs[w_addr[k]];
      for (int j = 0; j <= k; j++)
        if (w_eff[j] && (w_addr[j] == w_addr[k]))
          w_post[k] = merge_bytes(w_post[k], w_data[j], w_be[j]);
    end
  end

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    addr_t ra;
    word_t rv;
    logic  hit;
    readOutput = '0;
    readBusy   = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      ra  = readAddress[r*ADDR_WIDTH +: ADDR_WIDTH];
      rv  = regs[ra];
      hit = 1'b0;
      for (int k = 0; k < WRITE_PORTS; k++) begin
        if (w_eff[k] && (w_addr[k] == ra)) begin
          hit = 1'b1;
          if (BYPASS != 0) rv = merge_bytes(rv, w_data[k], w_be[k]);
        end
      end
      if (ra != '0) begin
        readOutput[r*DATA_WIDTH +: DATA_WIDTH] = rv;
        readBusy[r] = pending[ra] && !((BYPASS != 0) && hit);
      end
    end
  end

  logic                   pop;
  logic                   drop;
  logic [CNT_W-1:0]       free_slots;
  logic [CNT_W-1:0]       n_push;
  logic [WRITE_PORTS-1:0] push_ok;
  logic [PTR_W-1:0]       push_slot [WRITE_PORTS];

  // Lower-numbered ports claim free queue slots first; the rest are dropped.
  always_comb begin
    pop        = (count != '0);
    free_slots = TRACE_CAP - count + CNT_W'(pop);
    n_push     = '0;
    drop       = 1'b0;
    push_ok    = '0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      push_slot[k] = wr_ptr;
      if (w_eff[k]) begin
        if (n_push < free_slots) begin
          push_ok[k]   = 1'b1;
          push_slot[k] = wr_ptr + n_push[PTR_W-1:0];
          n_push       = n_push + CNT_W'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // NOTE: the register array is reset element by element because reads must
  // return 0 right after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending           <= '0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
      traceOverflow     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; when both ports hit one address
      // the later loop iteration wins, which is the intended port-1 priority.
      for (int k = 0; k < WRITE_PORTS; k++) begin
        if (w_eff[k]) begin
          regs[w_addr[k]]    <= w_post[k];
          pending[w_addr[k]] <= 1'b0;
        end
      end
      if (reserveValid && (reserveAddress != '0))
        pending[reserveAddress] <= 1'b1;

      if (pop) begin
        debug_wb_pc       <= fifo[rd_ptr].pc;
        debug_wb_rf_wen   <= fifo[rd_ptr].wen;
        debug_wb_rf_wnum  <= fifo[rd_ptr].wnum;
        debug_wb_rf_wdata <= fifo[rd_ptr].wdata;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end else begin
        debug_wb_rf_wen <= '0;
      end
      wr_ptr <= wr_ptr + n_push[PTR_W-1:0];
      count  <= count - CNT_W'(pop) + n_push;
      if (drop) traceOverflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < WRITE_PORTS; k++)
      if (!reset && push_ok[k])
        fifo[push_slot[k]] <= '{pc: w_pc[k], wnum: w_addr[k], wen: w_be[k], wdata: w_post[k]};
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised and directed bench for multiport_register_file, compared each cycle
// against a queue-based behavioural model of the register file and trace.
module tb_multiport_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam int BYP = 1;
  localparam int TD = 4;
  localparam int BY = DW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] r_addr [RP];
  logic          w_en   [WP];
  logic [AW-1:0] w_addr [WP];
  logic [DW-1:0] w_data [WP];
  logic [BY-1:0] w_be   [WP];
  logic [31:0]   w_pc   [WP];
  logic          rsv_v;
  logic [AW-1:0] rsv_a;

  logic [RP*AW-1:0] readAddress;
  logic [RP*DW-1:0] readOutput;
  logic [RP-1:0]    readBusy;
  logic [WP-1:0]    writeEnable;
  logic [WP*AW-1:0] writeAddress;
  logic [WP*DW-1:0] writeData;
  logic [WP*BY-1:0] writeByteEnable;
  logic [WP*32-1:0] writePC;
  logic [31:0]      debug_wb_pc;
  logic [BY-1:0]    debug_wb_rf_wen;
  logic [AW-1:0]    debug_wb_rf_wnum;
  logic [DW-1:0]    debug_wb_rf_wdata;
  logic             traceOverflow;

  always_comb begin
    for (int r = 0; r < RP; r++) readAddress[r*AW +: AW] = r_addr[r];
    for (int k = 0; k < WP; k++) begin
      writeEnable[k]              = w_en[k];
      writeAddress[k*AW +: AW]    = w_addr[k];
      writeData[k*DW +: DW]       = w_data[k];
      writeByteEnable[k*BY +: BY] = w_be[k];
      writePC[k*32 +: 32]         = w_pc[k];
    end
  end

  multiport_register_file #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP),
    .WRITE_PORTS(WP), .BYPASS(BYP), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset),
    .readAddress(readAddress), .readOutput(readOutput), .readBusy(readBusy),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .writeByteEnable(writeByteEnable), .writePC(writePC),
    .reserveValid(rsv_v), .reserveAddress(rsv_a),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .traceOverflow(traceOverflow)
  );

  typedef struct {
    logic [31:0]   pc;
    logic [AW-1:0] wnum;
    logic [BY-1:0] wen;
    logic [DW-1:0] wdata;
  } entry_t;

  logic [DW-1:0] m_reg [2**AW];
  bit            m_pend [2**AW];
  entry_t        m_q [$];
  bit            m_ovf;
  logic [31:0]   e_pc;
  logic [BY-1:0] e_wen;
  logic [AW-1:0] e_wnum;
  logic [DW-1:0] e_wdata;
  bit            known = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] apply(logic [DW-1:0] v, logic [DW-1:0] d, logic [BY-1:0] be);
    logic [DW-1:0] o;
    o = v;
    for (int b = 0; b < BY; b++) if (be[b]) o[b*8 +: 8] = d[b*8 +: 8];
    return o;
  endfunction

  function automatic bit eff(int k);
    return w_en[k] && (w_addr[k] != '0) && (w_be[k] != '0);
  endfunction

  // With bypass, a read sees the value the register will hold after the edge.
  function automatic logic [DW-1:0] exp_read(logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_reg[a];
    if (BYP != 0)
      for (int k = 0; k < WP; k++)
        if (eff(k) && w_addr[k] == a) v = apply(v, w_data[k], w_be[k]);
    return (a == '0) ? '0 : v;
  endfunction

  function automatic bit exp_busy(logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    if (BYP != 0)
      for (int k = 0; k < WP; k++)
        if (eff(k) && w_addr[k] == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_edge();
    entry_t h;
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
      m_q.delete();
      m_ovf = 1'b0; e_pc = '0; e_wen = '0; e_wnum = '0; e_wdata = '0;
      return;
    end
    if (m_q.size() > 0) begin
      h = m_q.pop_front();
      e_pc = h.pc; e_wen = h.wen; e_wnum = h.wnum; e_wdata = h.wdata;
    end else begin
      e_wen = '0;
    end
    for (int k = 0; k < WP; k++) begin
      if (eff(k)) begin
        m_reg[w_addr[k]]  = apply(m_reg[w_addr[k]], w_data[k], w_be[k]);
        m_pend[w_addr[k]] = 1'b0;
        if (m_q.size() < TD)
          m_q.push_back('{pc: w_pc[k], wnum: w_addr[k], wen: w_be[k], wdata: m_reg[w_addr[k]]});
        else
          m_ovf = 1'b1;
      end
    end
    if (rsv_v && rsv_a != '0) m_pend[rsv_a] = 1'b1;
  endtask

  task automatic idle();
    reset = 1'b0;
    rsv_v = 1'b0;
    rsv_a = '0;
    for (int r = 0; r < RP; r++) r_addr[r] = '0;
    for (int k = 0; k < WP; k++) begin
      w_en[k] = 1'b0; w_addr[k] = '0; w_data[k] = '0; w_be[k] = '0; w_pc[k] = '0;
    end
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [BY-1:0] be, input logic [31:0] pc);
    w_en[k] = 1'b1; w_addr[k] = a; w_data[k] = d; w_be[k] = be; w_pc[k] = pc;
  endtask

  // Inputs are driven 1ns after a posedge; outputs are checked mid-cycle and 1ns after the edge.
  task automatic step();
    #2;
    if (known) begin
      for (int r = 0; r < RP; r++) begin
        check($sformatf("read%0d", r), 64'(readOutput[r*DW +: DW]), 64'(exp_read(r_addr[r])));
        check($sformatf("busy%0d", r), 64'(readBusy[r]), 64'(exp_busy(r_addr[r])));
      end
    end
    @(posedge clk);
    model_edge();
    if (reset) known = 1'b1;
    #1;
    check("wb_wen", 64'(debug_wb_rf_wen), 64'(e_wen));
    check("wb_pc", 64'(debug_wb_pc), 64'(e_pc));
    check("wb_wnum", 64'(debug_wb_rf_wnum), 64'(e_wnum));
    check("wb_wdata", 64'(debug_wb_rf_wdata), 64'(e_wdata));
    check("overflow", 64'(traceOverflow), 64'(m_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b1;
    step();

    // Single write, then read back and watch the trace entry
    idle(); wr(0, 5'd3, 32'h12345678, 4'hF, 32'h100); step();
    idle(); r_addr[0] = 5'd3; #1;
    check("t1_read", 64'(readOutput[31:0]), 64'h12345678);
    step();
    check("t1_wnum", 64'(debug_wb_rf_wnum), 64'd3);
    check("t1_wen", 64'(debug_wb_rf_wen), 64'hF);
    idle(); step();
    check("t1_wen_clr", 64'(debug_wb_rf_wen), 64'h0);

    // Dual write to the same register with overlapping byte enables
    idle(); wr(0, 5'd5, 32'hAABBCCDD, 4'hF, 32'h200); step();
    idle();
    wr(0, 5'd5, 32'h11111111, 4'h3, 32'h204);
    wr(1, 5'd5, 32'h22222222, 4'h6, 32'h208);
    r_addr[0] = 5'd5; #1;
    check("t2_bypass", 64'(readOutput[31:0]), 64'hAA222211);
    step();
    idle(); step();
    check("t2_trace0", 64'(debug_wb_rf_wdata), 64'hAABB1111);
    idle(); step();
    check("t2_trace1", 64'(debug_wb_rf_wdata), 64'hAA222211);
    idle(); r_addr[1] = 5'd5; step();

    // Register 0 ignores writes and reserves
    idle(); wr(0, 5'd0, 32'hFFFFFFFF, 4'hF, 32'h300);
    rsv_v = 1'b1; rsv_a = 5'd0; step();
    idle(); r_addr[0] = 5'd0; #1;
    check("t3_read0", 64'(readOutput[31:0]), 64'h0);
    check("t3_busy0", 64'(readBusy[0]), 64'h0);
    step();
    check("t3_no_trace", 64'(debug_wb_rf_wen), 64'h0);

    // Scoreboard: reserve, write+reserve, then a plain write
    idle(); rsv_v = 1'b1; rsv_a = 5'd7; step();
    idle(); r_addr[0] = 5'd7; #1;
    check("t4_busy_set", 64'(readBusy[0]), 64'h1);
    wr(0, 5'd7, 32'h0000_0707, 4'hF, 32'h400); rsv_v = 1'b1; rsv_a = 5'd7; #1;
    check("t4_busy_bypass", 64'(readBusy[0]), 64'h0);
    step();
    idle(); r_addr[0] = 5'd7; #1;
    check("t4_busy_kept", 64'(readBusy[0]), 64'h1);
    wr(1, 5'd7, 32'h0000_7777, 4'h1, 32'h404); #1;
    check("t4_busy_wr", 64'(readBusy[0]), 64'h0);
    step();
    idle(); r_addr[0] = 5'd7; #1;
    check("t4_busy_clr", 64'(readBusy[0]), 64'h0);
    step();
    idle(); step(); step();

    // Overflow: two writes per cycle for four cycles into a 4-entry queue
    for (int c = 0; c < 4; c++) begin
      idle();
      wr(0, AW'(8 + 2*c), $urandom, 4'hF, 32'h500 + 32'(8*c));
      wr(1, AW'(9 + 2*c), $urandom, 4'hF, 32'h504 + 32'(8*c));
      step();
      if (c > 0) check("t5_order", 64'(debug_wb_rf_wnum), 64'(7 + c));
    end
    check("t5_ovf", 64'(traceOverflow), 64'h1);
    for (int i = 0; i < 4; i++) begin
      idle(); step();
      check("t5_drain", 64'(debug_wb_rf_wnum), 64'(11 + i));
    end
    idle(); step();
    check("t5_empty", 64'(debug_wb_rf_wen), 64'h0);

    // Reset with three queued entries and a pending register
    idle(); wr(0, 5'd20, 32'hCAFE0001, 4'hF, 32'h600); wr(1, 5'd21, 32'hCAFE0002, 4'hF, 32'h604); step();
    idle(); wr(0, 5'd22, 32'hCAFE0003, 4'hF, 32'h608); wr(1, 5'd23, 32'hCAFE0004, 4'hF, 32'h60C);
    rsv_v = 1'b1; rsv_a = 5'd24; step();
    idle(); reset = 1'b1; step();
    check("t6_wen", 64'(debug_wb_rf_wen), 64'h0);
    check("t6_ovf", 64'(traceOverflow), 64'h0);
    idle(); r_addr[0] = 5'd20; r_addr[1] = 5'd24; #1;
    check("t6_read", 64'(readOutput[31:0]), 64'h0);
    check("t6_busy", 64'(readBusy[1]), 64'h0);
    step();
    check("t6_wen_after", 64'(debug_wb_rf_wen), 64'h0);

    // Randomised traffic with alternating heavy and light write phases
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int k = 0; k < WP; k++) begin
        w_en[k]   = (((n / 40) % 2) == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        w_addr[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        w_data[k] = $urandom;
        w_be[k]   = BY'($urandom);
        w_pc[k]   = $urandom;
      end
      for (int r = 0; r < RP; r++)
        r_addr[r] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rsv_v = ($urandom_range(0, 2) == 0);
      rsv_a = AW'($urandom_range(0, 7));
      reset = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
